inst_mem_loader: RTL and testbench

Writable instruction memory that answers the `openmips` instruction-fetch port (`ce`/`addr`/`inst`) and is filled at boot from a byte-stream loader port. The memory replaces the fixed ROM in the minimal SOPC. A loader FSM does the following:
- assembles incoming bytes big-endian into 32-bit words;
- writes the words sequentially from word 0;
- raises `boot_done` when loading completes.

`boot_done` is intended to hold the core in reset until the image is in place. Fetch reads are combinational, so `openmips` sees no added latency.

---
 rtl/inst_mem_loader.sv | 149 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - writable instruction memory with a byte-stream boot loader
// Bytes are packed big-endian into words and written from word 0; fetch reads are combinational.
module inst_mem_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  input  logic                  ld_end,
  output logic [DEPTH_LOG2:0]   ld_words,
  output logic                  ld_err,
  output logic                  boot_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q;
  logic [1:0]           cnt_q;
  logic [DEPTH_LOG2:0]  ptr_q;
  logic [31:0]          word_q;
  logic [31:0]          word_d;
  logic                 ld_ready_q;
  logic                 boot_done_q;
  logic                 ld_err_q;

  logic [31:0]          mem [DEPTH];

  logic                 accept;
  logic                 word_full;
  logic                 flush;
  logic                 overflow;
  logic                 pending;
  logic                 wr_en;
  logic [31:0]          wr_data;
  logic [1:0]           unused_addr_lsb;

  assign accept    = (state_q == S_LOAD) && ld_valid && ld_ready_q && !ld_start;
  assign word_full = accept && (cnt_q == 2'd3);
  assign flush     = (state_q == S_FLUSH) && !ld_start;
  // ptr carries one extra bit so a full memory is distinguishable from an empty one
  assign overflow  = ptr_q[DEPTH_LOG2];
  assign pending   = accept ? (cnt_q != 2'd3) : (cnt_q != 2'd0);
  assign wr_en     = (word_full || flush) && !overflow;
  assign wr_data   = flush ? word_q : word_d;

  always_comb begin
    word_d = word_q;
    case (cnt_q)
      2'd0:    word_d[31:24] = ld_data;
      2'd1:    word_d[23:16] = ld_data;
      2'd2:    word_d[15:8]  = ld_data;
      default: word_d[7:0]   = ld_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      ptr_q       <= '0;
      word_q      <= '0;
      ld_ready_q  <= 1'b0;
      boot_done_q <= 1'b0;
      ld_err_q    <= 1'b0;
    end else if (ld_start) begin
      state_q     <= S_LOAD;
      cnt_q       <= 2'd0;
      ptr_q       <= '0;
      word_q      <= '0;
      ld_ready_q  <= 1'b1;
      boot_done_q <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_full ? '0 : word_d;
            if (word_full && !overflow) begin
              ptr_q <= ptr_q + PTR_ONE;
            end
          end
          if (word_full && overflow) begin
            state_q    <= S_ERROR;
            ld_err_q   <= 1'b1;
            ld_ready_q <= 1'b0;
          end else if (ld_end) begin
            ld_ready_q <= 1'b0;
            if (pending) begin
              state_q <= S_FLUSH;
            end else begin
              state_q     <= S_DONE;
              boot_done_q <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          cnt_q  <= 2'd0;
          word_q <= '0;
          if (overflow) begin
            state_q  <= S_ERROR;
            ld_err_q <= 1'b1;
          end else begin
            ptr_q       <= ptr_q + PTR_ONE;
            state_q     <= S_DONE;
            boot_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign unused_addr_lsb = addr[1:0];

  always_comb begin
    inst = 32'h0;
    if (ce && boot_done_q && (addr[31:DEPTH_LOG2+2] == '0)) begin
      inst = mem[addr[DEPTH_LOG2+1:2]];
    end
  end

  assign ld_ready  = ld_ready_q;
  assign ld_words  = ptr_q;
  assign ld_err    = ld_err_q;
  assign boot_done = boot_done_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed checks of the instruction memory loader
// Two instances: default depth for the load/fetch paths, DEPTH_LOG2=2 for overflow.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        ld_start, ld_valid, ld_end, ld_ready, ld_err, boot_done;
  logic [7:0]  ld_data;
  logic [10:0] ld_words;

  logic        s_rst, s_ce, s_start, s_valid, s_end, s_ready, s_err, s_done;
  logic [31:0] s_addr, s_inst;
  logic [7:0]  s_data;
  logic [2:0]  s_words;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_mem_loader #(.DEPTH_LOG2(10)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_end(ld_end), .ld_words(ld_words), .ld_err(ld_err), .boot_done(boot_done)
  );

  inst_mem_loader #(.DEPTH_LOG2(2)) u_small (
    .clk(clk), .rst(s_rst), .ce(s_ce), .addr(s_addr), .inst(s_inst),
    .ld_start(s_start), .ld_valid(s_valid), .ld_data(s_data), .ld_ready(s_ready),
    .ld_end(s_end), .ld_words(s_words), .ld_err(s_err), .boot_done(s_done)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  fetch_vec_t fv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic s_send(input logic [7:0] b, input logic last);
    s_valid = 1'b1;
    s_data  = b;
    s_end   = last;
    tick();
    s_valid = 1'b0;
    s_end   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img1[8];
    logic [7:0] img_s[16];

    fv[0] = '{1'b1, 32'h0000_0000, 32'h3401_1100};
    fv[1] = '{1'b1, 32'h0000_0004, 32'h3402_0020};
    fv[2] = '{1'b1, 32'h0000_0006, 32'h3402_0020};
    fv[3] = '{1'b1, 32'h0000_0003, 32'h3401_1100};
    fv[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    fv[5] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
    fv[6] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
    fv[7] = '{1'b1, 32'h8000_0004, 32'h0000_0000};

    img1 = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    img_s = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08, 8'h99, 8'h88, 8'h77, 8'h66};

    rst = 1'b0; ce = 1'b1; addr = 32'h0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_end = 1'b0; ld_data = 8'h00;
    s_rst = 1'b0; s_ce = 1'b1; s_addr = 32'h0;
    s_start = 1'b0; s_valid = 1'b0; s_end = 1'b0; s_data = 8'h00;
    tick();
    tick();
    check("reset boot_done", {31'b0, boot_done}, 32'h0);
    check("reset ld_ready", {31'b0, ld_ready}, 32'h0);
    check("reset ld_err", {31'b0, ld_err}, 32'h0);
    check("reset ld_words", {21'b0, ld_words}, 32'h0);
    check("reset inst", inst, 32'h0);
    rst = 1'b1;
    s_rst = 1'b1;
    tick();

    // Basic 8-byte image
    pulse_start();
    check("load ld_ready", {31'b0, ld_ready}, 32'h1);
    for (int i = 0; i < 8; i++) send_byte(img1[i]);
    check("pre-boot ld_words", {21'b0, ld_words}, 32'h2);
    check("pre-boot boot_done", {31'b0, boot_done}, 32'h0);
    addr = 32'h0;
    #1;
    check("pre-boot inst", inst, 32'h0);
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    check("img1 boot_done", {31'b0, boot_done}, 32'h1);
    check("img1 ld_words", {21'b0, ld_words}, 32'h2);
    check("img1 ld_ready", {31'b0, ld_ready}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      ce = fv[i].ce;
      addr = fv[i].addr;
      #1;
      check($sformatf("fetch vec %0d", i), inst, fv[i].exp);
    end
    ce = 1'b1;

    // Partial word via FLUSH, ld_end together with the 5th byte
    pulse_start();
    check("restart boot_done", {31'b0, boot_done}, 32'h0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    ld_end = 1'b1;
    send_byte(8'hAB);
    ld_end = 1'b0;
    check("flush boot_done", {31'b0, boot_done}, 32'h0);
    check("flush ld_ready", {31'b0, ld_ready}, 32'h0);
    check("flush ld_words", {21'b0, ld_words}, 32'h1);
    tick();
    check("flushed boot_done", {31'b0, boot_done}, 32'h1);
    check("flushed ld_words", {21'b0, ld_words}, 32'h2);
    addr = 32'h4; #1;
    check("flushed word1", inst, 32'hAB00_0000);
    addr = 32'h0; #1;
    check("flushed word0", inst, 32'h1122_3344);

    // Overflow on the small instance: 17 bytes, ld_end with the last one
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 16; i++) s_send(img_s[i], 1'b0);
    check("small full ld_words", {29'b0, s_words}, 32'h4);
    s_send(8'h55, 1'b1);
    check("small flush ld_err", {31'b0, s_err}, 32'h0);
    tick();
    check("small ovf ld_err", {31'b0, s_err}, 32'h1);
    check("small ovf boot_done", {31'b0, s_done}, 32'h0);
    check("small ovf ld_words", {29'b0, s_words}, 32'h4);
    tick();
    check("small err sticky", {31'b0, s_err}, 32'h1);
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("small restart ld_err", {31'b0, s_err}, 32'h0);
    s_end = 1'b1; tick(); s_end = 1'b0;
    check("small empty boot_done", {31'b0, s_done}, 32'h1);
    check("small empty ld_words", {29'b0, s_words}, 32'h0);
    s_addr = 32'h0; #1;
    check("small word0 kept", s_inst, 32'hDEAD_BEEF);
    s_addr = 32'hC; #1;
    check("small word3", s_inst, 32'h9988_7766);
    s_addr = 32'h10; #1;
    check("small out of range", s_inst, 32'h0);

    // Asynchronous reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i));
    check("midload ld_words", {21'b0, ld_words}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst ld_words", {21'b0, ld_words}, 32'h0);
    check("async rst ld_ready", {31'b0, ld_ready}, 32'h0);
    check("async rst boot_done", {31'b0, boot_done}, 32'h0);
    check("async rst ld_err", {31'b0, ld_err}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    pulse_start();
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    ld_end = 1'b1; tick(); ld_end = 1'b0;
    check("post-rst ld_words", {21'b0, ld_words}, 32'h1);
    check("post-rst boot_done", {31'b0, boot_done}, 32'h1);
    addr = 32'h0; #1;
    check("post-rst word0", inst, 32'hCAFE_F00D);

    // Gaps in ld_valid and ld_start mid-load
    pulse_start();
    send_byte(8'h01); send_byte(8'h02);
    tick(); tick(); tick();
    send_byte(8'h03); send_byte(8'h04);
    check("gap ld_words", {21'b0, ld_words}, 32'h1);
    send_byte(8'h05);
    tick(); tick(); tick();
    send_byte(8'h06);
    pulse_start();
    check("midload restart ld_words", {21'b0, ld_words}, 32'h0);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    ld_end = 1'b1; tick(); ld_end = 1'b0;
    check("restart boot_done", {31'b0, boot_done}, 32'h1);
    check("restart ld_words", {21'b0, ld_words}, 32'h1);
    addr = 32'h0; #1;
    check("restart word0", inst, 32'hA1A2_A3A4);
    addr = 32'h4; #1;
    check("dropped partial word1", inst, 32'hAB00_0000);

    // ld_valid and ld_end in DONE are ignored
    send_byte(8'hEE); send_byte(8'hEF);
    ld_end = 1'b1; tick(); ld_end = 1'b0;
    check("done ignore ld_words", {21'b0, ld_words}, 32'h1);
    check("done ignore boot_done", {31'b0, boot_done}, 32'h1);
    addr = 32'h0; #1;
    check("done ignore word0", inst, 32'hA1A2_A3A4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
